// File: rtl/fetch_decode_buffer_pkg.sv
// Shared fetch/decode types: packet struct, buffer FSM states, opcodes.
// Used by fetch_decode_buffer (optional FDB_BYPASS_EN) and the decoder.
package fetch_decode_buffer_pkg;

  typedef logic [31:0] fdb_word_t;

  typedef struct packed {
    fdb_word_t instr;
    fdb_word_t pc;
  } fetch_pkt_t;

  typedef enum logic {
    FDB_RUN,
    FDB_WAIT_REDIRECT
  } fdb_state_e;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  function automatic logic [6:0] opcode_of(
    input fdb_word_t instr
  );
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-side and decode-side handshakes of the instruction queue.
// master = surrounding pipeline, slave = the buffer.
interface fetch_decode_buffer_if
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_fetch_valid;
  fdb_word_t     i_fetch_instr;
  fdb_word_t     i_fetch_pc;
  logic          o_fetch_ready;
  logic          o_dec_valid;
  fdb_word_t     o_dec_instr;
  fdb_word_t     o_dec_pc;
  logic          i_dec_ready;
  logic          i_flush;
  fdb_word_t     i_redirect_pc;
  logic [CW-1:0] o_count;

  modport master (
    output i_fetch_valid,
    output i_fetch_instr,
    output i_fetch_pc,
    input  o_fetch_ready,
    input  o_dec_valid,
    input  o_dec_instr,
    input  o_dec_pc,
    output i_dec_ready,
    output i_flush,
    output i_redirect_pc,
    input  o_count
  );

  modport slave (
    input  i_fetch_valid,
    input  i_fetch_instr,
    input  i_fetch_pc,
    output o_fetch_ready,
    output o_dec_valid,
    output o_dec_instr,
    output o_dec_pc,
    input  i_dec_ready,
    input  i_flush,
    input  i_redirect_pc,
    output o_count
  );

endinterface

// File: rtl/fetch_decode_buffer_storage.sv
// fdb_storage: DEPTH x fetch_pkt_t register array,
// one write port, one async read port, data not reset.
module fdb_storage
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_pkt_t    wdata,
  input  logic [AW-1:0] raddr,
  output fetch_pkt_t    rdata
);

  fetch_pkt_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Fetch->decode instruction queue with flush/redirect filtering.
// Define FDB_BYPASS_EN for 0-cycle pass-through when empty.
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  fetch_decode_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fdb_state_e    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  fdb_word_t     redirect_pc_q;

  fetch_pkt_t head;
  fetch_pkt_t wr_pkt;
  logic running;
  logic has_data;
  logic match;
  logic push;
  logic pop;
  logic wr_en;
  logic bypass;

  assign running  = (state == FDB_RUN);
  assign has_data = (count != '0);
  assign match    = (bus.i_fetch_pc == redirect_pc_q);

  assign bus.o_fetch_ready = (count < FULL) & ~bus.i_flush;

  // While waiting for the redirect target, non-matching packets
  // are handshaken but never written.
  assign push = bus.i_fetch_valid & bus.o_fetch_ready
              & (running | match);

`ifdef FDB_BYPASS_EN
  assign bypass = push & running & ~has_data;
`else
  assign bypass = 1'b0;
`endif

  assign pop = has_data & running
             & bus.i_dec_ready & ~bus.i_flush;

  assign wr_en = push & ~(bypass & bus.i_dec_ready);

  assign wr_pkt = '{instr: bus.i_fetch_instr,
                    pc:    bus.i_fetch_pc};

  assign bus.o_dec_valid = (has_data & running) | bypass;

  always_comb begin
    bus.o_dec_instr = '0;
    bus.o_dec_pc    = '0;
    if (bypass) begin
      bus.o_dec_instr = bus.i_fetch_instr;
      bus.o_dec_pc    = bus.i_fetch_pc;
    end else if (bus.o_dec_valid) begin
      bus.o_dec_instr = head.instr;
      bus.o_dec_pc    = head.pc;
    end
  end

  assign bus.o_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FDB_RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      redirect_pc_q <= '0;
    end else if (bus.i_flush) begin
      state         <= FDB_WAIT_REDIRECT;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      redirect_pc_q <= bus.i_redirect_pc;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
      if (!running && push) state <= FDB_RUN;
    end
  end

  fdb_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_pkt),
    .raddr (rd_ptr),
    .rdata (head)
  );

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed self-checking bench for fetch_decode_buffer (DEPTH=4).
// Build with FDB_BYPASS_EN to check the bypass expectations.
module tb_fetch_decode_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  fetch_decode_buffer_if #(.DEPTH(4)) bus ();

  fetch_decode_buffer #(
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(
    input logic        v,
    input logic [31:0] pc,
    input logic [31:0] instr
  );
    bus.i_fetch_valid = v;
    bus.i_fetch_pc    = pc;
    bus.i_fetch_instr = instr;
    #1;
  endtask

  initial begin
    bus.i_fetch_valid = 1'b0;
    bus.i_fetch_instr = '0;
    bus.i_fetch_pc    = '0;
    bus.i_dec_ready   = 1'b0;
    bus.i_flush       = 1'b0;
    bus.i_redirect_pc = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_ready", 32'(bus.o_fetch_ready), 1);
    chk("rst_valid", 32'(bus.o_dec_valid), 0);
    chk("rst_pc", bus.o_dec_pc, 0);
    chk("rst_instr", bus.o_dec_instr, 0);
    rst_n = 1'b1;
    cyc();

    // 1: fill, stall, drain in order
    for (int i = 0; i < 4; i++) begin
      fetch(1'b1, 32'(i * 4), 32'h1000 + 32'(i));
      chk("fill_ready", 32'(bus.o_fetch_ready), 1);
      cyc();
    end
    fetch(1'b1, 32'h10, 32'h1010);
    chk("full_count", 32'(bus.o_count), 4);
    chk("full_ready", 32'(bus.o_fetch_ready), 0);
    chk("full_head", bus.o_dec_pc, 32'h0);
    cyc();
    chk("stall_count", 32'(bus.o_count), 4);
    fetch(1'b0, 0, 0);
    bus.i_dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", 32'(bus.o_dec_valid), 1);
      chk("drain_pc", bus.o_dec_pc, 32'(i * 4));
      chk("drain_instr", bus.o_dec_instr,
          32'h1000 + 32'(i));
      cyc();
    end
    bus.i_dec_ready = 1'b0;
    #1;
    chk("empty_count", 32'(bus.o_count), 0);
    chk("empty_valid", 32'(bus.o_dec_valid), 0);

    // 2: push+pop while full
    for (int i = 0; i < 4; i++) begin
      fetch(1'b1, 32'h20 + 32'(i * 4), 32'h2000 + 32'(i));
      cyc();
    end
    fetch(1'b1, 32'h30, 32'h2004);
    bus.i_dec_ready = 1'b1;
    #1;
    chk("sim_ready0", 32'(bus.o_fetch_ready), 0);
    chk("sim_head0", bus.o_dec_pc, 32'h20);
    cyc();
    chk("sim_count1", 32'(bus.o_count), 3);
    chk("sim_ready1", 32'(bus.o_fetch_ready), 1);
    chk("sim_head1", bus.o_dec_pc, 32'h24);
    cyc();
    chk("sim_count2", 32'(bus.o_count), 3);
    fetch(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("sim_drain", bus.o_dec_pc, 32'h28 + 32'(i * 4));
      cyc();
    end
    chk("sim_instr_last", 32'(bus.o_count), 0);
    bus.i_dec_ready = 1'b0;

    // 3: flush with redirect to 0x200
    for (int i = 0; i < 3; i++) begin
      fetch(1'b1, 32'h50 + 32'(i * 4), 32'h5000);
      cyc();
    end
    chk("fl_pre_count", 32'(bus.o_count), 3);
    bus.i_flush = 1'b1;
    bus.i_redirect_pc = 32'h200;
    fetch(1'b1, 32'h5c, 32'h5000);
    chk("fl_ready", 32'(bus.o_fetch_ready), 0);
    cyc();
    bus.i_flush = 1'b0;
    fetch(1'b1, 32'h10, 32'h1);
    chk("fl_count", 32'(bus.o_count), 0);
    chk("fl_valid", 32'(bus.o_dec_valid), 0);
    chk("fl_drop_ready", 32'(bus.o_fetch_ready), 1);
    cyc();
    fetch(1'b1, 32'h14, 32'h2);
    chk("fl_drop1", 32'(bus.o_count), 0);
    cyc();
    fetch(1'b1, 32'h200, 32'habc);
    chk("fl_drop2", 32'(bus.o_count), 0);
    chk("fl_wait_valid", 32'(bus.o_dec_valid), 0);
    cyc();
    fetch(1'b0, 0, 0);
    chk("fl_tgt_valid", 32'(bus.o_dec_valid), 1);
    chk("fl_tgt_pc", bus.o_dec_pc, 32'h200);
    chk("fl_tgt_instr", bus.o_dec_instr, 32'habc);
    chk("fl_tgt_count", 32'(bus.o_count), 1);
    bus.i_dec_ready = 1'b1;
    cyc();
    bus.i_dec_ready = 1'b0;

    // 4: double flush, only the latest target counts
    bus.i_flush = 1'b1;
    bus.i_redirect_pc = 32'h100;
    cyc();
    bus.i_redirect_pc = 32'h300;
    cyc();
    bus.i_flush = 1'b0;
    fetch(1'b1, 32'h100, 32'h111);
    cyc();
    fetch(1'b0, 0, 0);
    chk("df_drop_count", 32'(bus.o_count), 0);
    chk("df_drop_valid", 32'(bus.o_dec_valid), 0);
    fetch(1'b1, 32'h300, 32'h333);
    cyc();
    fetch(1'b0, 0, 0);
    chk("df_tgt_valid", 32'(bus.o_dec_valid), 1);
    chk("df_tgt_pc", bus.o_dec_pc, 32'h300);
    bus.i_dec_ready = 1'b1;
    cyc();
    bus.i_dec_ready = 1'b0;

    // 5: async reset mid-stream
    fetch(1'b1, 32'h60, 32'h6060);
    cyc();
    fetch(1'b1, 32'h64, 32'h6464);
    cyc();
    fetch(1'b0, 0, 0);
    chk("ar_pre_count", 32'(bus.o_count), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(bus.o_count), 0);
    chk("ar_valid", 32'(bus.o_dec_valid), 0);
    chk("ar_ready", 32'(bus.o_fetch_ready), 1);
    chk("ar_pc", bus.o_dec_pc, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    fetch(1'b1, 32'h40, 32'h4444);
    cyc();
    fetch(1'b0, 0, 0);
    chk("ar_post_valid", 32'(bus.o_dec_valid), 1);
    chk("ar_post_pc", bus.o_dec_pc, 32'h40);
    chk("ar_post_instr", bus.o_dec_instr, 32'h4444);
    chk("ar_post_count", 32'(bus.o_count), 1);
    bus.i_dec_ready = 1'b1;
    cyc();
    chk("ar_post_empty", 32'(bus.o_count), 0);

    // 6: empty push with decoder ready
    fetch(1'b1, 32'h80, 32'h8080);
`ifdef FDB_BYPASS_EN
    chk("bp_valid", 32'(bus.o_dec_valid), 1);
    chk("bp_pc", bus.o_dec_pc, 32'h80);
    chk("bp_instr", bus.o_dec_instr, 32'h8080);
    cyc();
    fetch(1'b0, 0, 0);
    chk("bp_count", 32'(bus.o_count), 0);
    chk("bp_after", 32'(bus.o_dec_valid), 0);
`else
    chk("nb_valid0", 32'(bus.o_dec_valid), 0);
    cyc();
    fetch(1'b0, 0, 0);
    chk("nb_count", 32'(bus.o_count), 1);
    chk("nb_valid1", 32'(bus.o_dec_valid), 1);
    chk("nb_pc", bus.o_dec_pc, 32'h80);
    cyc();
    chk("nb_empty", 32'(bus.o_count), 0);
`endif
    bus.i_dec_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
